// File: rtl/imem_program_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_program_encoder                                         |
// | Description : Encodes abstract lw/sw/R-type/beq requests into RV32I words  |
// |               and writes them sequentially into instruction memory.        |
// |               Optional macro IMEM_NOP_PAD_EN: after finish, pad the unused |
// |               slots with NOP (addi x0, x0, 0) up to DEPTH.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_program_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    parameter int          CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       kind,
    input  logic [2:0]       alu_sel,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [12:0]      imm,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);
    localparam logic [31:0]      c_nop       = 32'h0000_0013;
    localparam logic [6:0]       c_op_load   = 7'b0000011;
    localparam logic [6:0]       c_op_store  = 7'b0100011;
    localparam logic [6:0]       c_op_reg    = 7'b0110011;
    localparam logic [6:0]       c_op_branch = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
`ifdef IMEM_NOP_PAD_EN
        S_PAD  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [6:0]       w_f7;
    logic [2:0]       w_f3;
    logic             w_alu_ok;
    logic [31:0]      w_word;
    logic             w_legal;
    logic             w_accept;
    logic             w_write;
    logic [31:0]      w_slot_addr;

    // A restart request takes priority over the handshake in the same cycle.
    assign in_ready    = (r_state == S_LOAD) && (r_count < c_depth) && !start;
    assign w_accept    = in_valid && in_ready;
    assign w_write     = w_accept && w_legal;
    assign w_slot_addr = BASE_ADDR + (32'(r_count) << 2);

    // Encode the current request and decide whether it is a legal instruction.
    always_comb begin
        w_f7     = 7'b0000000;
        w_f3     = 3'b000;
        w_alu_ok = 1'b1;
        case (alu_sel)
            3'd0:    w_f3 = 3'b000;
            3'd1:    w_f7 = 7'b0100000;
            3'd2:    w_f3 = 3'b111;
            3'd3:    w_f3 = 3'b110;
            3'd4:    w_f3 = 3'b010;
            default: w_alu_ok = 1'b0;
        endcase

        w_word  = 32'h0;
        w_legal = 1'b1;
        case (kind)
            2'b00: w_word = {imm[11:0], rs1, 3'b010, rd, c_op_load};
            2'b01: w_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], c_op_store};
            2'b10: begin
                w_word  = {w_f7, rs2, rs1, w_f3, rd, c_op_reg};
                w_legal = w_alu_ok;
            end
            default: begin
                w_word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], c_op_branch};
                w_legal = ~imm[0];
            end
        endcase
    end

    // Program-load state machine with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 32'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (start) begin
                r_state <= S_LOAD;
                r_count <= '0;
                r_err   <= 1'b0;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            if (w_legal) begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_slot_addr;
                                r_mem_wdata <= w_word;
                                r_count     <= r_count + CNT_W'(1);
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        if (finish) begin
`ifdef IMEM_NOP_PAD_EN
                            // Nothing left to pad and nothing in flight: finish now.
                            if (!w_write && (r_count == c_depth)) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_PAD;
                            end
`else
                            // With a write in flight, done is raised one cycle later in S_DONE.
                            r_state <= S_DONE;
                            if (!w_write) begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef IMEM_NOP_PAD_EN
                    S_PAD: begin
                        if (r_count < c_depth) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_slot_addr;
                            r_mem_wdata <= c_nop;
                            r_count     <= r_count + CNT_W'(1);
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
`endif
                    S_DONE: begin
                        if (r_busy) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_program_encoder                                      |
// | Description : Self-checking bench for imem_program_encoder. Two instances  |
// |               (DEPTH 64 at base 0, DEPTH 4 at base 0x1000) share stimulus  |
// |               and are checked every cycle against a transaction model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_program_encoder;

    localparam logic [31:0] BASE_B = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, finish, in_valid;
    logic [1:0]  kind;
    logic [2:0]  alu_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;

    logic        ready_a, we_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a;
    logic [6:0]  count_a;
    logic        ready_b, we_b, busy_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [2:0]  count_b;

    imem_program_encoder #(.BASE_ADDR(32'h0), .DEPTH(64), .CNT_W(7)) dut_a (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(ready_a), .kind(kind), .alu_sel(alu_sel),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err(err_a), .count(count_a));

    imem_program_encoder #(.BASE_ADDR(BASE_B), .DEPTH(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(ready_b), .kind(kind), .alu_sel(alu_sel),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err(err_b), .count(count_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_started [2];
    bit          m_finished[2];
    bit          m_we      [2];
    bit          m_done    [2];
    bit          m_err     [2];
    int          m_cnt     [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_wdata   [2];

    function automatic int depth_of(input int d);
        return (d == 0) ? 64 : 4;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : BASE_B;
    endfunction

    function automatic bit ref_legal(input logic [1:0] k, input logic [2:0] a, input logic [12:0] im);
        if (k == 2'd2) return (a <= 3'd4);
        if (k == 2'd3) return (im[0] == 1'b0);
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_word(input logic [1:0] k, input logic [2:0] a,
                                             input logic [4:0] d_rd, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [12:0] im);
        int unsigned i, r_d, r1, r2, f3, f7;
        i  = 32'(im);
        r_d = 32'(d_rd);
        r1 = 32'(s1);
        r2 = 32'(s2);
        f3 = 0;
        f7 = 0;
        case (k)
            2'd0: return ((i & 32'hFFF) << 20) | (r1 << 15) | (2 << 12) | (r_d << 7) | 3;
            2'd1: return (((i >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (2 << 12)
                         | ((i & 32'h1F) << 7) | 35;
            2'd2: begin
                case (a)
                    3'd1:    f7 = 32;
                    3'd2:    f3 = 7;
                    3'd3:    f3 = 6;
                    3'd4:    f3 = 2;
                    default: f3 = 0;
                endcase
                return (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (r_d << 7) | 51;
            end
            default: return (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | (r2 << 20)
                            | (r1 << 15) | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7) | 99;
        endcase
    endfunction

    function automatic bit model_ready(input int d);
        return m_started[d] && !m_finished[d] && (m_cnt[d] < depth_of(d)) && !start;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit rdy;
            bit prev_fin;
            rdy      = model_ready(d);
            prev_fin = m_finished[d];
            if (rst) begin
                m_started[d] = 0; m_finished[d] = 0; m_we[d] = 0; m_done[d] = 0;
                m_err[d] = 0; m_cnt[d] = 0; m_addr[d] = base_of(d); m_wdata[d] = 32'h0;
            end else if (start) begin
                m_started[d] = 1; m_finished[d] = 0; m_we[d] = 0; m_done[d] = 0;
                m_err[d] = 0; m_cnt[d] = 0;
            end else begin
                m_we[d] = 0;
                if (in_valid && rdy) begin
                    if (ref_legal(kind, alu_sel, imm)) begin
                        m_we[d]    = 1;
                        m_addr[d]  = base_of(d) + 32'(4 * m_cnt[d]);
                        m_wdata[d] = ref_word(kind, alu_sel, rd, rs1, rs2, imm);
                        m_cnt[d]++;
                    end else begin
                        m_err[d] = 1;
                    end
                end
                if (m_started[d] && !m_finished[d] && finish) m_finished[d] = 1;
`ifdef IMEM_NOP_PAD_EN
                if (prev_fin && m_cnt[d] < depth_of(d)) begin
                    m_we[d]    = 1;
                    m_addr[d]  = base_of(d) + 32'(4 * m_cnt[d]);
                    m_wdata[d] = 32'h0000_0013;
                    m_cnt[d]++;
                end
                if (m_finished[d] && !m_we[d] && m_cnt[d] == depth_of(d)) m_done[d] = 1;
`else
                if (prev_fin) begin end
                if (m_finished[d] && !m_we[d]) m_done[d] = 1;
`endif
            end
        end
    endtask

    task automatic compare_all();
        chk("A_mem_we", 32'(we_a), 32'(m_we[0]));
        if (m_we[0]) begin
            chk("A_mem_addr", addr_a, m_addr[0]);
            chk("A_mem_wdata", wdata_a, m_wdata[0]);
        end
        chk("A_done", 32'(done_a), 32'(m_done[0]));
        chk("A_busy", 32'(busy_a), 32'(m_started[0] && !m_done[0]));
        chk("A_err", 32'(err_a), 32'(m_err[0]));
        chk("A_count", 32'(count_a), 32'(m_cnt[0]));
        chk("B_mem_we", 32'(we_b), 32'(m_we[1]));
        if (m_we[1]) begin
            chk("B_mem_addr", addr_b, m_addr[1]);
            chk("B_mem_wdata", wdata_b, m_wdata[1]);
        end
        chk("B_done", 32'(done_b), 32'(m_done[1]));
        chk("B_busy", 32'(busy_b), 32'(m_started[1] && !m_done[1]));
        chk("B_err", 32'(err_b), 32'(m_err[1]));
        chk("B_count", 32'(count_b), 32'(m_cnt[1]));
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            chk("A_in_ready", 32'(ready_a), 32'(model_ready(0)));
            chk("B_in_ready", 32'(ready_b), 32'(model_ready(1)));
        end
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 0; finish = 0; in_valid = 0;
    endtask

    task automatic set_req(input logic [1:0] k, input logic [2:0] a, input logic [4:0] d_rd,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im);
        in_valid = 1; kind = k; alu_sel = a; rd = d_rd; rs1 = s1; rs2 = s2; imm = im;
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  alu;
        logic [4:0]  rd, rs1, rs2;
        logic [12:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int nw;
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = base_of(d);
            m_wdata[d] = 32'h0;
        end
        rst = 1; idle_inputs();
        kind = 0; alu_sel = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;

        vecs[0]  = '{2'd0, 3'd0, 5'd5,  5'd2,  5'd0,  13'd8,     1'b1, 32'h00812283};
        vecs[1]  = '{2'd0, 3'd0, 5'd1,  5'd0,  5'd0,  13'h1FFF,  1'b1, 32'hFFF02083};
        vecs[2]  = '{2'd1, 3'd0, 5'd31, 5'd2,  5'd6,  13'd12,    1'b1, 32'h00612623};
        vecs[3]  = '{2'd1, 3'd0, 5'd0,  5'd3,  5'd4,  13'h1FF8,  1'b1, 32'hFE41AC23};
        vecs[4]  = '{2'd2, 3'd0, 5'd1,  5'd2,  5'd3,  13'd0,     1'b1, 32'h003100B3};
        vecs[5]  = '{2'd2, 3'd1, 5'd3,  5'd1,  5'd2,  13'd0,     1'b1, 32'h402081B3};
        vecs[6]  = '{2'd2, 3'd2, 5'd4,  5'd5,  5'd6,  13'd0,     1'b1, 32'h0062F233};
        vecs[7]  = '{2'd2, 3'd3, 5'd7,  5'd8,  5'd9,  13'd0,     1'b1, 32'h009463B3};
        vecs[8]  = '{2'd2, 3'd4, 5'd10, 5'd11, 5'd12, 13'd0,     1'b1, 32'h00C5A533};
        vecs[9]  = '{2'd3, 3'd0, 5'd0,  5'd1,  5'd2,  13'h1FFC,  1'b1, 32'hFE208EE3};
        vecs[10] = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  13'h0FFE,  1'b1, 32'h7E000FE3};
        vecs[11] = '{2'd2, 3'd5, 5'd1,  5'd1,  5'd1,  13'd0,     1'b0, 32'h0};
        vecs[12] = '{2'd3, 3'd0, 5'd0,  5'd1,  5'd2,  13'd3,     1'b0, 32'h0};
        vecs[13] = '{2'd2, 3'd7, 5'd1,  5'd1,  5'd1,  13'd0,     1'b0, 32'h0};

        // Reset state
        tick(); tick();
        rst = 0;
        chk("reset_we",    32'(we_a), 32'h0);
        chk("reset_busy",  32'(busy_a), 32'h0);
        chk("reset_done",  32'(done_a), 32'h0);
        chk("reset_err",   32'(err_a), 32'h0);
        chk("reset_count", 32'(count_a), 32'h0);
        chk("reset_ready", 32'(ready_a), 32'h0);
        chk("reset_addr",  addr_b, BASE_B);
        chk("reset_wdata", wdata_a, 32'h0);

        // Encoding table, one fresh program per vector
        for (int v = 0; v < 14; v++) begin
            start = 1; tick(); start = 0;
            set_req(vecs[v].kind, vecs[v].alu, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].imm);
            tick(); idle_inputs();
            chk($sformatf("vec%0d_we", v), 32'(we_a), 32'(vecs[v].legal));
            chk($sformatf("vec%0d_err", v), 32'(err_a), 32'(!vecs[v].legal));
            if (vecs[v].legal) begin
                chk($sformatf("vec%0d_word", v), wdata_a, vecs[v].word);
                chk($sformatf("vec%0d_addr", v), addr_a, 32'h0);
            end
        end

        // Back-to-back writes on consecutive cycles
        start = 1; tick(); start = 0;
        set_req(2'd1, 3'd0, 5'd0, 5'd2, 5'd6, 13'd12); tick();
        chk("b2b_first_we", 32'(we_a), 32'h1);
        chk("b2b_first_addr", addr_a, 32'h0);
        chk("b2b_first_word", wdata_a, 32'h00612623);
        set_req(2'd2, 3'd1, 5'd3, 5'd1, 5'd2, 13'd0); tick();
        chk("b2b_second_we", 32'(we_a), 32'h1);
        chk("b2b_second_addr", addr_a, 32'h4);
        chk("b2b_second_word", wdata_a, 32'h402081B3);

`ifndef IMEM_NOP_PAD_EN
        // Last request together with finish: done one cycle after the write
        set_req(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC); finish = 1; tick(); idle_inputs();
        chk("fin_we", 32'(we_a), 32'h1);
        chk("fin_word", wdata_a, 32'hFE208EE3);
        chk("fin_done_early", 32'(done_a), 32'h0);
        tick();
        chk("fin_done", 32'(done_a), 32'h1);
        chk("fin_busy", 32'(busy_a), 32'h0);
        chk("fin_no_write", 32'(we_a), 32'h0);
`endif

        // Illegal requests are consumed without a write and set a sticky err
        idle_inputs(); start = 1; tick(); start = 0;
        set_req(2'd2, 3'd7, 5'd1, 5'd1, 5'd1, 13'd0); tick();
        chk("ill_r_we", 32'(we_a), 32'h0);
        chk("ill_r_err", 32'(err_a), 32'h1);
        set_req(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 13'd3); tick(); idle_inputs();
        chk("ill_beq_we", 32'(we_a), 32'h0);
        chk("ill_count", 32'(count_a), 32'h0);
        tick();
        chk("ill_err_held", 32'(err_a), 32'h1);
        start = 1; tick(); start = 0;
        chk("ill_err_cleared", 32'(err_a), 32'h0);

        // Fill the 4-slot instance, then reset mid-load
        set_req(2'd0, 3'd0, 5'd5, 5'd2, 5'd0, 13'd8);
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (we_b) nw++;
        end
        chk("full_writes", 32'(nw), 32'd4);
        chk("full_count", 32'(count_b), 32'd4);
        chk("full_ready", 32'(ready_b), 32'h0);
        rst = 1; tick();
        chk("rst_mid_we", 32'(we_a), 32'h0);
        chk("rst_mid_busy", 32'(busy_a), 32'h0);
        chk("rst_mid_count", 32'(count_a), 32'h0);
        rst = 0; idle_inputs(); tick();
        chk("rst_no_stray_a", 32'(we_a), 32'h0);
        chk("rst_no_stray_b", 32'(we_b), 32'h0);

`ifdef IMEM_NOP_PAD_EN
        // One lw then finish: the 4-slot instance pads slots 1..3 with NOPs
        start = 1; tick(); start = 0;
        set_req(2'd0, 3'd0, 5'd5, 5'd2, 5'd0, 13'd8); finish = 1; tick(); idle_inputs();
        chk("pad_lw_addr", addr_b, BASE_B);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("pad%0d_we", i), 32'(we_b), 32'h1);
            chk($sformatf("pad%0d_addr", i), addr_b, BASE_B + 32'(4 * i));
            chk($sformatf("pad%0d_word", i), wdata_b, 32'h0000_0013);
        end
        tick();
        chk("pad_done", 32'(done_b), 32'h1);
        chk("pad_busy", 32'(busy_b), 32'h0);
        for (int i = 0; i < 100 && !done_a; i++) tick();
        chk("pad_a_done", 32'(done_a), 32'h1);
`endif

        // Randomized traffic checked against the model every cycle
        for (int c = 0; c < 2500; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 39) == 0);
            finish   = ($urandom_range(0, 29) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            kind     = 2'($urandom_range(0, 3));
            alu_sel  = 3'($urandom_range(0, 7));
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            imm      = 13'($urandom);
            if (kind == 2'd3 && $urandom_range(0, 7) != 0) imm[0] = 1'b0;
            tick();
        end
        rst = 0; idle_inputs(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
